// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and constants for the iterative shift unit
// Contents:
//   SHAMT_W         width of the shift amount (RV32I: 5 bits)
//   shift_op_e      SLL / SRL / SRA / reserved operation codes
//   state_e         controller states
//   op_is_reserved  ops that return operand_a untouched (SRA too when SHIFT_SRA_EN is undefined)
package shift_pkg;

   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b10,
      SHIFT_RSV = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_e;

   function automatic logic op_is_reserved(input shift_op_e op);
`ifdef SHIFT_SRA_EN
      return (op == SHIFT_RSV);
`else
      return (op == SHIFT_RSV) || (op == SHIFT_SRA);
`endif
   endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - one combinational shift step of 0..MAX_STEP bits
// Optional feature macro: SHIFT_SRA_EN (arithmetic right shift; without it op SRA passes data through)
// Ports:
//   i_data  [XLEN-1:0]     value to shift
//   i_step  [SHAMT_W-1:0]  bits to shift this step
//   i_op    shift_op_e     operation
//   o_data  [XLEN-1:0]     shifted value
module shift_step
   import shift_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]    i_data,
   input  logic [SHAMT_W-1:0] i_step,
   input  shift_op_e          i_op,
   output logic [XLEN-1:0]    o_data
);

   always_comb begin
      o_data = i_data;
      case (i_op)
         SHIFT_SLL: o_data = i_data << i_step;
         SHIFT_SRL: o_data = i_data >> i_step;
`ifdef SHIFT_SRA_EN
         // The sign bit survives every step, so repeated steps keep filling
         // with the original sign.
         SHIFT_SRA: o_data = $unsigned($signed(i_data) >>> i_step);
`endif
         default:   o_data = i_data;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// rtl/shift_seq_ctrl.sv - multi-cycle SLL/SRL/SRA controller with valid/ready handshakes
// Optional feature macro: SHIFT_SRA_EN (enables op 10 as arithmetic right shift)
// Ports:
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_valid/o_ready  request handshake (o_ready high only in IDLE)
//   i_op             00 SLL, 01 SRL, 10 SRA, 11 reserved
//   i_operand_a      value to shift
//   i_operand_b      shift amount, bits [4:0] used
//   i_flush          aborts any transaction, highest priority
//   o_valid/i_ready  result handshake
//   o_shift_data     result, forced to 0 while o_valid is low
//   o_busy           high in SHIFT or DONE
module shift_seq_ctrl
   import shift_pkg::*;
#(
   parameter int MAX_STEP = 4,
   parameter int XLEN     = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [1:0]      i_op,
   input  logic [XLEN-1:0] i_operand_a,
   input  logic [XLEN-1:0] i_operand_b,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_shift_data,
   output logic            o_busy
);

   localparam logic [SHAMT_W-1:0] MAX_STEP_W = SHAMT_W'(MAX_STEP);

   state_e              state_q, state_d;
   logic [XLEN-1:0]     data_q, data_d;
   logic [SHAMT_W-1:0]  rem_q, rem_d;
   shift_op_e           op_q, op_d;

   logic [SHAMT_W-1:0]  step;
   logic [XLEN-1:0]     step_data;
   shift_op_e           in_op;
   logic [SHAMT_W-1:0]  in_shamt;

   // Upper shift-amount bits are architecturally ignored.
   logic unused_operand_b_hi;
   assign unused_operand_b_hi = ^i_operand_b[XLEN-1:SHAMT_W];

   assign in_op    = shift_op_e'(i_op);
   assign in_shamt = i_operand_b[SHAMT_W-1:0];
   assign step     = (rem_q < MAX_STEP_W) ? rem_q : MAX_STEP_W;

   shift_step #(
      .XLEN (XLEN)
   ) u_shift_step (
      .i_data (data_q),
      .i_step (step),
      .i_op   (op_q),
      .o_data (step_data)
   );

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      rem_d   = rem_q;
      op_d    = op_q;

      if (i_flush) begin
         state_d = ST_IDLE;
         data_d  = '0;
         rem_d   = '0;
         op_d    = SHIFT_SLL;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (i_valid) begin
                  data_d  = i_operand_a;
                  rem_d   = in_shamt;
                  op_d    = in_op;
                  state_d = ((in_shamt != '0) && !op_is_reserved(in_op)) ? ST_SHIFT : ST_DONE;
               end
            end
            ST_SHIFT: begin
               data_d = step_data;
               rem_d  = rem_q - step;
               // This is the last step once what remains fits in one step.
               if (rem_q <= MAX_STEP_W) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               if (i_ready) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         data_q  <= '0;
         rem_q   <= '0;
         op_q    <= SHIFT_SLL;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         op_q    <= op_d;
      end
   end

   assign o_ready      = (state_q == ST_IDLE);
   assign o_valid      = (state_q == ST_DONE);
   assign o_busy       = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign o_shift_data = o_valid ? data_q : '0;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb/tb_shift_seq_ctrl.sv - directed self-checking bench for shift_seq_ctrl (MAX_STEP=4)
// Optional feature macro: SHIFT_SRA_EN (selects the SRA expectations)
module tb_shift_seq_ctrl;

   logic        clk;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [1:0]  i_op;
   logic [31:0] i_operand_a;
   logic [31:0] i_operand_b;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_shift_data;
   logic        o_busy;

   int tests_run;
   int tests_failed;

   shift_seq_ctrl #(
      .MAX_STEP (4),
      .XLEN     (32)
   ) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_op         (i_op),
      .i_operand_a  (i_operand_a),
      .i_operand_b  (i_operand_b),
      .i_flush      (i_flush),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_shift_data (o_shift_data),
      .o_busy       (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ready"}, {31'd0, o_ready}, 32'd1);
      check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
      check({tag, "_busy"},  {31'd0, o_busy},  32'd0);
      check({tag, "_data"},  o_shift_data,     32'd0);
   endtask

   // Issues one request from a negedge; edges counts posedges from the
   // accept edge (inclusive) until o_valid is seen.
   task automatic run_req(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int exp_edges,
                          input logic [31:0] exp_data, input int hold);
      int   edges;
      logic busy_ok;
      @(negedge clk);
      i_valid     = 1'b1;
      i_op        = op;
      i_operand_a = a;
      i_operand_b = b;
      i_ready     = 1'b0;
      check({tag, "_ready_pre"}, {31'd0, o_ready}, 32'd1);
      @(negedge clk);
      i_valid = 1'b0;
      edges   = 1;
      busy_ok = 1'b1;
      while (o_valid !== 1'b1 && edges < 64) begin
         if (o_busy !== 1'b1 || o_ready !== 1'b0) busy_ok = 1'b0;
         @(negedge clk);
         edges++;
      end
      check({tag, "_latency"}, edges, exp_edges);
      check({tag, "_result"}, o_shift_data, exp_data);
      check({tag, "_busy_during"}, {31'd0, busy_ok}, 32'd1);
      check({tag, "_busy_done"}, {31'd0, o_busy}, 32'd1);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
         check({tag, "_hold_data"}, o_shift_data, exp_data);
      end
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      check_idle({tag, "_after"});
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      i_valid      = 1'b0;
      i_op         = 2'b00;
      i_operand_a  = 32'd0;
      i_operand_b  = 32'd0;
      i_flush      = 1'b0;
      i_ready      = 1'b0;

      #2;
      check_idle("reset");
      #10;
      rst = 1'b0;

      run_req("sll31", 2'b00, 32'h0000_0001, 32'd31, 9, 32'h8000_0000, 0);
      run_req("srl5", 2'b01, 32'hF000_000F, 32'hFFFF_FFE5, 3, 32'h0780_0000, 0);
`ifdef SHIFT_SRA_EN
      run_req("sra7", 2'b10, 32'h8000_0000, 32'd7, 3, 32'hFF00_0000, 0);
      run_req("sra31", 2'b10, 32'hF000_0000, 32'd31, 9, 32'hFFFF_FFFF, 0);
      run_req("sra30pos", 2'b10, 32'h4000_0000, 32'd30, 9, 32'h0000_0001, 0);
`else
      run_req("sra7", 2'b10, 32'h8000_0000, 32'd7, 1, 32'h8000_0000, 0);
      run_req("sra31", 2'b10, 32'hF000_0000, 32'd31, 1, 32'hF000_0000, 0);
`endif
      run_req("rsv0", 2'b11, 32'hDEAD_BEEF, 32'd0, 1, 32'hDEAD_BEEF, 3);
      run_req("rsv9", 2'b11, 32'hDEAD_BEEF, 32'd9, 1, 32'hDEAD_BEEF, 0);
      run_req("sll_sh0", 2'b00, 32'h1234_5678, 32'd0, 1, 32'h1234_5678, 0);
      run_req("sll4", 2'b00, 32'h0000_0001, 32'd4, 2, 32'h0000_0010, 0);
      run_req("srl8", 2'b01, 32'h0000_0100, 32'd8, 3, 32'h0000_0001, 0);

      // Flush in the second SHIFT cycle, colliding with i_valid and i_ready.
      @(negedge clk);
      i_valid     = 1'b1;
      i_op        = 2'b00;
      i_operand_a = 32'h0000_0001;
      i_operand_b = 32'd20;
      @(negedge clk);
      i_valid = 1'b0;
      check("flush_busy_shift", {31'd0, o_busy}, 32'd1);
      @(negedge clk);
      i_flush = 1'b1;
      i_valid = 1'b1;
      i_ready = 1'b1;
      @(negedge clk);
      i_flush = 1'b0;
      i_valid = 1'b0;
      i_ready = 1'b0;
      check_idle("flush");
      begin
         logic saw_valid;
         saw_valid = 1'b0;
         for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (o_valid !== 1'b0) saw_valid = 1'b1;
         end
         check("flush_no_result", {31'd0, saw_valid}, 32'd0);
      end
      run_req("post_flush", 2'b00, 32'h0000_0001, 32'd1, 2, 32'h0000_0002, 0);

      // Flush in IDLE must not accept a simultaneous request.
      @(negedge clk);
      i_valid     = 1'b1;
      i_flush     = 1'b1;
      i_op        = 2'b11;
      i_operand_a = 32'hCAFE_F00D;
      i_operand_b = 32'd0;
      @(negedge clk);
      i_valid = 1'b0;
      i_flush = 1'b0;
      check_idle("flush_idle");

      // Asynchronous reset in the middle of SHIFT.
      @(negedge clk);
      i_valid     = 1'b1;
      i_op        = 2'b00;
      i_operand_a = 32'h0000_0001;
      i_operand_b = 32'd31;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", {31'd0, o_busy}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_idle("rst_mid");
      #1;
      rst = 1'b0;
      run_req("post_rst", 2'b01, 32'h8000_0000, 32'd31, 9, 32'h0000_0001, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
